// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath types and defaults
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } adder_state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 4;

endpackage

// File: rtl/chunk_adder_slice.sv
// rtl/chunk_adder_slice.sv - combinational CHUNK-bit ripple slice built from full-adder cells
module chunk_adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .sum  (sum[i]),
      .cout (w_carry[i+1])
    );
  end

  // Carry into the top bit is what signed-overflow detection needs.
  assign cout  = w_carry[CHUNK];
  assign c_msb = w_carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle add/sub resolving CHUNK bits per clock
module chunk_serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  adder_state_e     r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_sub;
  logic [IDXW-1:0]  r_idx;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_c_msb;
  logic [WIDTH-1:0] w_sum_ins;
  logic             w_accept;
  logic             w_last;

  // Operands shift down so the slice always sees the current chunk in the low bits;
  // results enter at the top, so after NCHUNK steps chunk k sits in its own position.
  chunk_adder_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (r_a[CHUNK-1:0]),
    .b     (r_b[CHUNK-1:0]),
    .cin   (r_carry),
    .sum   (w_slice_sum),
    .cout  (w_slice_cout),
    .c_msb (w_slice_c_msb)
  );

  assign w_sum_ins = WIDTH'(w_slice_sum) << (WIDTH - CHUNK);
  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_last    = (r_idx == IDXW'(NCHUNK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= c_in ^ sub;
            r_sub   <= sub;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= (r_sum >> CHUNK) | w_sum_ins;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_cout  <= w_slice_cout ^ r_sub;
            r_ovf   <= w_slice_c_msb ^ w_slice_cout;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - self-checking bench for chunk_serial_adder
module tb_chunk_serial_adder;

  localparam int W = 16;
  localparam int C = 4;
  localparam int NCH = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  chunk_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer-arithmetic reference: add is a+b+cin, sub is a-b-cin with borrow.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       input logic ms, output logic [W-1:0] rs, output logic rc, output logic rv);
    int ia, ib, ic, full;
    ia = int'(ma);
    ib = int'(mb);
    ic = int'(mc);
    if (!ms) begin
      full = ia + ib + ic;
      rs = W'(full);
      rc = (full >= (1 << W));
      rv = (ma[W-1] == mb[W-1]) && (rs[W-1] != ma[W-1]);
    end else begin
      full = ia - ib - ic;
      rs = W'(full);
      rc = (full < 0);
      rv = (ma[W-1] != mb[W-1]) && (rs[W-1] != ma[W-1]);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input logic [W-1:0] es,
                        input logic ec, input logic ev, input int hold, input logic bp);
    int lat;
    int waited;
    logic [W-1:0] held_sum;
    logic held_c, held_v;
    @(negedge clk);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    c_in = tc;
    sub = ts;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept_wait"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c_in = 1'($urandom);
    sub = 1'($urandom);
    lat = 0;
    for (int e = 1; e <= 20 && lat == 0; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = e;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NCH));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_c_out"}, 32'(c_out), 32'(ec));
    check({tag, "_overflow"}, 32'(overflow), 32'(ev));
    held_sum = sum;
    held_c = c_out;
    held_v = overflow;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bp) begin
        in_valid = i[0];
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk);
      #1;
      if (bp) begin
        check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_bp_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_bp_stable"}, {15'd0, held_c, held_v, held_sum},
              {15'd0, c_out, overflow, sum});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_release_out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    if (bp) begin
      @(posedge clk);
      #1;
      check({tag, "_no_accept"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic rc, rs, ec, ev;
    int hold;

    #2;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", {30'd0, c_out, overflow} | 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add1",    16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 0, 1'b0);
    run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
    run_op("cin",     16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 2, 1'b0);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 0, 1'b0);
    run_op("borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 0, 1'b0);
    run_op("borrow1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b1, 1'b0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (n % 6 == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
      hold = int'($urandom_range(0, 3));
      model(ra, rb, rc, rs, es, ec, ev);
      run_op("rand", ra, rb, rc, rs, es, ec, ev, hold, 1'b0);
    end

    model(16'h4321, 16'h1111, 1'b1, 1'b1, es, ec, ev);
    run_op("backpressure", 16'h4321, 16'h1111, 1'b1, 1'b1, es, ec, ev, 10, 1'b1);

    @(negedge clk);
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1357;
    c_in = 1'b0;
    sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_outputs", {30'd0, c_out, overflow} | 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
